// File: rtl/ps2_pkg.sv
// Purpose: shared constants and frame layout for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: frame/data widths, default queue depth and abort timeout,
//           the on-wire frame struct and its validity check.
package ps2_pkg;

  localparam int FRAME_BITS          = 11;
  localparam int DATA_BITS           = 8;
  localparam int DEFAULT_FIFO_DEPTH  = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 50000;

  // Bit 0 is the first bit on the wire (start), bit 10 the last (stop).
  typedef struct packed {
    logic                 stop;
    logic                 parity;
    logic [DATA_BITS-1:0] payload;
    logic                 start;
  } ps2_frame_t;

  // Odd parity: payload ones plus the parity bit must be an odd count.
  function automatic logic frame_ok(input ps2_frame_t f);
    return !f.start && f.stop && ((^f.payload) ^ f.parity);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Purpose: small synchronous queue for received bytes, head shown combinationally.
// Latency: a push is visible on rd_data/ready the cycle after the write edge.
// Backpressure: none upstream; a push into a full queue without a pop is dropped and flags overflow.
// Ports: clk, reset (sync, active-high); wr_en/wr_data push side;
//        rd_en pop side; rd_data head (0 when empty), ready = not empty, overflow sticky.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             ready,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = rd_en && !empty;
  // When full, a same-cycle pop frees the head slot, which is the slot written.
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: it is never observable while empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign ready   = !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Purpose: PS/2 keyboard frame receiver with byte queue and per-bit strobe output.
// Latency: byte pushed the cycle after the stop edge is detected (3 clk after the raw fall incl. sync), readable one cycle later.
// Backpressure: none toward the keyboard; full queue drops new bytes and sets sticky overflow.
// Ports: clk, reset (sync, active-high); ps2_clk/ps2_data raw async inputs; rd_en pop;
//        data/ready queue head; overflow sticky; frame_err pulse; bit_out/bit_valid data-bit strobe.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 overflow,
  output logic                 frame_err,
  output logic                 bit_out,
  output logic                 bit_valid
);

  localparam logic [3:0]  LAST_BIT     = 4'(FRAME_BITS - 1);
  localparam logic [3:0]  LAST_DATA    = 4'(DATA_BITS);
  localparam logic [15:0] IDLE_LIMIT   = 16'(TIMEOUT_CYC);

  // Index 0 is stage 1 (closest to the pin), index 2 is stage 3.
  logic [2:0]            clk_sync;
  logic [2:0]            dat_sync;
  logic                  fall;
  logic                  sdata;

  logic [3:0]            bit_cnt;
  // Holds the first ten bits; the eleventh is taken live on the stop edge
  // so the frame is checked in the same cycle it completes.
  logic [FRAME_BITS-2:0] shreg;
  logic [15:0]           idle_cnt;
  ps2_frame_t            frame_next;
  logic                  last_edge;

  logic                  push;
  logic [DATA_BITS-1:0]  push_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  assign fall       = clk_sync[2] && !clk_sync[1];
  assign sdata      = dat_sync[2];
  assign frame_next = {sdata, shreg};
  assign last_edge  = fall && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      frame_err <= 1'b0;
      push      <= 1'b0;
      push_byte <= '0;
    end else begin
      bit_valid <= 1'b0;
      frame_err <= 1'b0;
      push      <= 1'b0;

      if (fall) begin
        shreg    <= frame_next[FRAME_BITS-1:1];
        idle_cnt <= '0;
        bit_cnt  <= last_edge ? 4'd0 : bit_cnt + 4'd1;
        // Counts 1..8 are the payload; start, parity and stop are not strobed.
        if (bit_cnt >= 4'd1 && bit_cnt <= LAST_DATA) begin
          bit_valid <= 1'b1;
          bit_out   <= sdata;
        end
        if (last_edge) begin
          push      <= frame_ok(frame_next);
          frame_err <= !frame_ok(frame_next);
          push_byte <= frame_next.payload;
        end
      end else if (bit_cnt == 4'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_LIMIT) begin
        // Keyboard went quiet mid-frame: drop the partial frame silently.
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  ps2_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (push_byte),
    .rd_en    (rd_en),
    .rd_data  (data),
    .ready    (ready),
    .overflow (overflow)
  );

endmodule
